// File: rtl/system_0_led_sequencer_if.sv
// system_0_led_sequencer_if: groups the config-slave bus, the PIO write-master
// bus and the interrupt line of the LED sequencer into one bundle.
//   slave  : view taken by the sequencer itself
//   master : view taken by the system side (CPU/interconnect, PIO, IRQ sink)
interface system_0_led_sequencer_if;
  // Config slave (CPU -> sequencer)
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  // Write master (sequencer -> PIO s1)
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [31:0] m_writedata;
  // Interrupt
  logic        irq;

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, m_address, m_chipselect, m_write_n, m_writedata, irq
  );
endinterface

// File: rtl/system_0_led_sequencer.sv
// system_0_led_sequencer: Avalon-MM register slave plus a write master that
// plays a CPU-loaded pattern table into the green-LED PIO data register, one
// pattern per step, once or looping.
// Optional feature macro: LED_SEQ_BLANK_ON_STOP_EN -- when defined, every stop
// (completion or abort) is followed by one extra PIO write of 0.
module system_0_led_sequencer #(
  parameter int DATA_WIDTH   = 9,
  parameter int DEPTH        = 8,
  parameter int PERIOD_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  system_0_led_sequencer_if.slave bus
);

  localparam int IDX_W = 3;
  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_PERIOD = 4'd1;
  localparam logic [3:0] ADDR_LENGTH = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;
  localparam logic [3:0] ADDR_TBL    = 4'd4;
  localparam logic [4:0] TBL_END     = 5'(4 + DEPTH);
  localparam logic [3:0] DEPTH_L     = 4'(DEPTH);
  localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(2);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_BLANK} state_e;

  state_e                  state_q, state_d;
  logic                    run_q, run_d;
  logic                    loop_q, loop_d;
  logic                    irq_en_q, irq_en_d;
  logic                    done_q, done_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0]              length_q, length_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    m_cs_q, m_cs_d;
  logic                    m_wn_q, m_wn_d;
  logic [31:0]             m_wd_q, m_wd_d;
  logic [DATA_WIDTH-1:0]   table_q [DEPTH];

  logic                    cpu_wr, ctrl_wr, start_req, stop_req, tbl_hit;
  logic [IDX_W-1:0]        tbl_off;
  logic [3:0]              eff_len;
  logic                    last_step;
  logic [PERIOD_WIDTH-1:0] reload;
  logic                    fetch, stop_seq;
  logic [IDX_W-1:0]        fetch_idx;
  logic                    unused_wdata;

  assign cpu_wr    = bus.chipselect & ~bus.write_n;
  assign ctrl_wr   = cpu_wr && (bus.address == ADDR_CTRL);
  assign start_req = ctrl_wr &  bus.writedata[0];
  assign stop_req  = ctrl_wr & ~bus.writedata[0];
  assign tbl_off   = IDX_W'(bus.address - ADDR_TBL);
  assign tbl_hit   = ({1'b0, bus.address} >= 5'(ADDR_TBL)) && ({1'b0, bus.address} < TBL_END);

  // LENGTH 0 behaves as 1 and anything above DEPTH behaves as DEPTH. Using >=
  // lets a LENGTH shrunk below the current index end the pass at the next step.
  assign eff_len   = (length_q == 4'd0) ? 4'd1 : ((length_q > DEPTH_L) ? DEPTH_L : length_q);
  assign last_step = ({1'b0, index_q} >= (eff_len - 4'd1));

  // Strobe-to-strobe spacing is PERIOD clocks: one WRITE cycle plus PERIOD-1
  // WAIT cycles, the last of which sees the counter at zero.
  assign reload = (period_q < MIN_PERIOD) ? '0 : (period_q - MIN_PERIOD);

  assign unused_wdata = ^bus.writedata[31:PERIOD_WIDTH];

  // Combinational register readback, zero-extended, no wait states.
  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_CTRL:   bus.readdata[2:0] = {irq_en_q, loop_q, run_q};
      ADDR_PERIOD: bus.readdata[PERIOD_WIDTH-1:0] = period_q;
      ADDR_LENGTH: bus.readdata[3:0] = length_q;
      ADDR_STATUS: begin
        bus.readdata[0]   = (state_q != S_IDLE);
        bus.readdata[6:4] = index_q;
        bus.readdata[8]   = done_q;
      end
      default: if (tbl_hit) bus.readdata[DATA_WIDTH-1:0] = table_q[tbl_off];
    endcase
  end

  // Next-state logic for config registers, sequencer FSM and master outputs.
  always_comb begin
    // NOTE: every _d starts from a default so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    run_d     = run_q;
    loop_d    = loop_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    period_d  = period_q;
    length_d  = length_q;
    index_d   = index_q;
    cnt_d     = cnt_q;
    m_cs_d    = 1'b0;
    m_wn_d    = 1'b1;
    m_wd_d    = m_wd_q;
    fetch     = 1'b0;
    fetch_idx = '0;
    stop_seq  = 1'b0;

    // Config writes; run is handled by the FSM so a run=1 while busy is ignored.
    if (cpu_wr) begin
      case (bus.address)
        ADDR_CTRL: begin
          loop_d   = bus.writedata[1];
          irq_en_d = bus.writedata[2];
          done_d   = 1'b0;
        end
        ADDR_PERIOD: period_d = bus.writedata[PERIOD_WIDTH-1:0];
        ADDR_LENGTH: length_d = bus.writedata[3:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          fetch = 1'b1;
          run_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (stop_req) begin
          stop_seq = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = reload;
        end
      end
      S_WAIT: begin
        // An abort in the same cycle as a step boundary takes priority.
        if (stop_req) begin
          stop_seq = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end else if (!last_step) begin
          fetch     = 1'b1;
          fetch_idx = index_q + IDX_W'(1);
        end else if (loop_q) begin
          fetch = 1'b1;
        end else begin
          stop_seq = 1'b1;
          done_d   = 1'b1;
        end
      end
`ifdef LED_SEQ_BLANK_ON_STOP_EN
      S_BLANK: begin
        // A run=1 arriving during the blanking write starts the next pass right after it.
        if (start_req) begin
          fetch  = 1'b1;
          run_d  = 1'b1;
          done_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (stop_seq) begin
      run_d = 1'b0;
`ifdef LED_SEQ_BLANK_ON_STOP_EN
      state_d = S_BLANK;
      m_cs_d  = 1'b1;
      m_wn_d  = 1'b0;
      m_wd_d  = '0;
`else
      state_d = S_IDLE;
`endif
    end

    // The pattern is fetched at strobe launch, so table edits land on the next fetch.
    if (fetch) begin
      state_d = S_WRITE;
      index_d = fetch_idx;
      m_cs_d  = 1'b1;
      m_wn_d  = 1'b0;
      m_wd_d  = 32'(table_q[fetch_idx]);
    end
  end

  // Control, status, counter and registered master outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      run_q    <= 1'b0;
      loop_q   <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      period_q <= '0;
      length_q <= '0;
      index_q  <= '0;
      cnt_q    <= '0;
      m_cs_q   <= 1'b0;
      m_wn_q   <= 1'b1;
      m_wd_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      run_q    <= run_d;
      loop_q   <= loop_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      period_q <= period_d;
      length_q <= length_d;
      index_q  <= index_d;
      cnt_q    <= cnt_d;
      m_cs_q   <= m_cs_d;
      m_wn_q   <= m_wn_d;
      m_wd_q   <= m_wd_d;
    end
  end

  // Pattern table: CPU-written, read by the fetch path and the readback mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the table is a few flops with a defined power-up value, so it resets like any register instead of being left as uninitialised RAM.
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (cpu_wr && tbl_hit) begin
      table_q[tbl_off] <= bus.writedata[DATA_WIDTH-1:0];
    end
  end

  assign bus.m_address    = 2'b00;
  assign bus.m_chipselect = m_cs_q;
  assign bus.m_write_n    = m_wn_q;
  assign bus.m_writedata  = m_wd_q;
  assign bus.irq          = done_q & irq_en_q;

endmodule
